// File: rtl/ethernet_pkg.sv
// Shared types and constants for the Ethernet RX deframer: header layout, header struct,
// deframer FSM states and a byte-lane helper.
package ethernet_pkg;

  localparam logic [47:0] MAC_BCAST = 48'hffffffffffff;

  // Byte offsets within the two header beats
  localparam int unsigned DstOff   = 0;  // beat 0
  localparam int unsigned SrcHiOff = 6;  // beat 0
  localparam int unsigned SrcLoOff = 0;  // beat 1
  localparam int unsigned TypeOff  = 4;  // beat 1
  localparam int unsigned DestOff  = 6;  // beat 1

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
    logic [7:0]  dest;
  } eth_hdr_t;

  typedef enum logic [1:0] {StHdr0, StHdr1, StPass, StDrop} rx_state_e;

  function automatic logic [7:0] beat_byte(logic [63:0] beat, int unsigned n);
    return beat[8*n +: 8];
  endfunction

endpackage

// File: rtl/eth_rx_deframer_if.sv
// 64-bit frame stream with per-frame sideband (kernel destination, source MAC).
interface eth_rx_deframer_if;
  logic [63:0] DATA;
  logic [7:0]  KEEP;
  logic        LAST;
  logic        VALID;
  logic        READY;
  logic [7:0]  DEST;
  logic [47:0] SRC_MAC;

  modport master (output DATA, KEEP, LAST, VALID, DEST, SRC_MAC, input READY);
  modport slave  (input DATA, KEEP, LAST, VALID, DEST, SRC_MAC, output READY);
endinterface

// File: rtl/axis_reg_slice.sv
// Single-stage ready/valid output register; reloads on the same cycle it is popped.
module axis_reg_slice (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [63:0] data_q;
  logic [7:0]  keep_q;
  logic        last_q;
  logic        valid_q;

  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
        keep_q <= in_keep;
        last_q <= in_last;
      end
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/eth_rx_deframer.sv
// Ethernet RX deframer: filters on destination MAC, strips the 16-byte header and forwards
// payload with DEST/SRC_MAC sideband. Frame counters built only when ETH_RX_STATS_EN is defined.
module eth_rx_deframer
  import ethernet_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02
) (
  input  logic                clk,
  input  logic                rst,
  eth_rx_deframer_if.slave    stream_in,
  eth_rx_deframer_if.master   stream_out,
  output logic [31:0]         frames_ok,
  output logic [31:0]         frames_dropped
);

  rx_state_e   state_q;
  logic        mac_ok_q;
  logic [15:0] src_hi_q;
  logic [7:0]  dest_q;
  logic [47:0] src_mac_q;

  logic        slice_ready;
  logic        in_fire;
  logic        full_hdr;
  eth_hdr_t    hdr;

  assign stream_in.READY = (state_q == StPass) ? slice_ready : 1'b1;
  assign in_fire         = stream_in.VALID && stream_in.READY;
  assign full_hdr        = (stream_in.KEEP == 8'hff) && !stream_in.LAST;

  // Fields as they would appear on the current beat; dst is meaningful in HDR0, the rest in HDR1.
  always_comb begin
    hdr.dst = {beat_byte(stream_in.DATA, DstOff),     beat_byte(stream_in.DATA, DstOff + 1),
               beat_byte(stream_in.DATA, DstOff + 2), beat_byte(stream_in.DATA, DstOff + 3),
               beat_byte(stream_in.DATA, DstOff + 4), beat_byte(stream_in.DATA, DstOff + 5)};
    hdr.src = {src_hi_q,
               beat_byte(stream_in.DATA, SrcLoOff),     beat_byte(stream_in.DATA, SrcLoOff + 1),
               beat_byte(stream_in.DATA, SrcLoOff + 2), beat_byte(stream_in.DATA, SrcLoOff + 3)};
    hdr.ethertype = {beat_byte(stream_in.DATA, TypeOff), beat_byte(stream_in.DATA, TypeOff + 1)};
    hdr.dest      = beat_byte(stream_in.DATA, DestOff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHdr0;
      mac_ok_q  <= 1'b0;
      src_hi_q  <= '0;
      dest_q    <= '0;
      src_mac_q <= '0;
    end else if (in_fire) begin
      unique case (state_q)
        StHdr0: begin
          mac_ok_q <= (hdr.dst == MAC_ADDR_FPGA) || (hdr.dst == MAC_BCAST);
          src_hi_q <= {beat_byte(stream_in.DATA, SrcHiOff), beat_byte(stream_in.DATA, SrcHiOff + 1)};
          if (full_hdr) state_q <= StHdr1;
        end
        StHdr1: begin
          dest_q    <= hdr.dest;
          src_mac_q <= hdr.src;
          if (!full_hdr)     state_q <= StHdr0;
          else if (mac_ok_q) state_q <= StPass;
          else               state_q <= StDrop;
        end
        StPass, StDrop: begin
          if (stream_in.LAST) state_q <= StHdr0;
        end
        default: state_q <= StHdr0;
      endcase
    end
  end

  axis_reg_slice u_out_slice (
    .clk       (clk),
    .rst       (rst),
    .in_data   (stream_in.DATA),
    .in_keep   (stream_in.KEEP),
    .in_last   (stream_in.LAST),
    .in_valid  (stream_in.VALID && (state_q == StPass)),
    .in_ready  (slice_ready),
    .out_data  (stream_out.DATA),
    .out_keep  (stream_out.KEEP),
    .out_last  (stream_out.LAST),
    .out_valid (stream_out.VALID),
    .out_ready (stream_out.READY)
  );

  assign stream_out.DEST    = dest_q;
  assign stream_out.SRC_MAC = src_mac_q;

`ifdef ETH_RX_STATS_EN
  logic        ok_inc;
  logic        drop_inc;
  logic [31:0] frames_ok_q;
  logic [31:0] frames_dropped_q;

  assign ok_inc   = in_fire && (state_q == StPass) && stream_in.LAST;
  // Runt headers count on the offending beat; filtered frames count on their LAST beat.
  assign drop_inc = in_fire && ((((state_q == StHdr0) || (state_q == StHdr1)) && !full_hdr) ||
                                ((state_q == StDrop) && stream_in.LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_ok_q      <= '0;
      frames_dropped_q <= '0;
    end else begin
      if (ok_inc)   frames_ok_q      <= frames_ok_q + 32'd1;
      if (drop_inc) frames_dropped_q <= frames_dropped_q + 32'd1;
    end
  end

  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;
`else
  assign frames_ok      = 32'h0;
  assign frames_dropped = 32'h0;
`endif

  logic unused_bits;
  assign unused_bits = ^{hdr.ethertype, stream_in.DEST, stream_in.SRC_MAC};

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Directed self-checking bench for eth_rx_deframer (counters checked against 0 unless
// ETH_RX_STATS_EN is defined).
module tb_eth_rx_deframer;

`ifdef ETH_RX_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  localparam logic [63:0] HdrMatch0 = 64'hc40c02ca553e16fa;  // dst fa163e55ca02, src hi 0cc4
  localparam logic [63:0] HdrMatch1 = 64'h0005b58847c0887a;  // src lo 7a88c047, DEST 05
  localparam logic [63:0] HdrWrong0 = 64'hc40c665544332211;  // dst 112233445566
  localparam logic [63:0] HdrBcast0 = 64'hb2a1ffffffffffff;  // dst bcast, src hi a1b2
  localparam logic [63:0] HdrBcast1 = 64'h0009b588f6e5d4c3;  // src lo c3d4e5f6, DEST 09
  localparam logic [47:0] SrcMatch  = 48'h0cc47a88c047;
  localparam logic [47:0] SrcBcast  = 48'ha1b2c3d4e5f6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] frames_ok;
  logic [31:0] frames_dropped;

  always #5 clk = ~clk;

  eth_rx_deframer_if s_in ();
  eth_rx_deframer_if s_out ();

  eth_rx_deframer dut (
    .clk            (clk),
    .rst            (rst),
    .stream_in      (s_in),
    .stream_out     (s_out),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  dest;
    logic [47:0] src;
  } beat_t;

  beat_t got_q[$];
  int    valid_cycles = 0;
  int    passes = 0;
  int    fails = 0;
  int    checks = 0;
  int    stalls = 0;
  int    exp_ok = 0;
  int    exp_drop = 0;
  int    vc0;

  always @(negedge clk) begin
    if (s_out.VALID) valid_cycles++;
    if (s_out.VALID && s_out.READY)
      got_q.push_back({s_out.DATA, s_out.KEEP, s_out.LAST, s_out.DEST, s_out.SRC_MAC});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [63:0] d,
                          input logic [7:0] k, input logic l, input logic [7:0] dest,
                          input logic [47:0] src);
    if (idx < got_q.size()) begin
      chk({tag, "_data"}, got_q[idx].data, d);
      chk({tag, "_keep"}, {56'h0, got_q[idx].keep}, {56'h0, k});
      chk({tag, "_last"}, {63'h0, got_q[idx].last}, {63'h0, l});
      chk({tag, "_dest"}, {56'h0, got_q[idx].dest}, {56'h0, dest});
      chk({tag, "_src"}, {16'h0, got_q[idx].src}, {16'h0, src});
    end else begin
      chk({tag, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_frames_ok"}, {32'h0, frames_ok}, StatsEn ? 64'(exp_ok) : 64'h0);
    chk({tag, "_frames_dropped"}, {32'h0, frames_dropped}, StatsEn ? 64'(exp_drop) : 64'h0);
  endtask

  // Entered and left at posedge+1; returns once the beat has been accepted.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int   n = 0;
    logic rdy;
    s_in.DATA  = d;
    s_in.KEEP  = k;
    s_in.LAST  = l;
    s_in.VALID = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_in.READY;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("in_ready_timeout", {63'h0, rdy}, 64'h1);
    stalls += n - 1;
    s_in.VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_in.DATA    = '0;
    s_in.KEEP    = '0;
    s_in.LAST    = 1'b0;
    s_in.VALID   = 1'b0;
    s_in.DEST    = '0;
    s_in.SRC_MAC = '0;
    s_out.READY  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, s_out.VALID}, 64'h0);
    chk("rst_out_data", s_out.DATA, 64'h0);
    chk("rst_out_keep", {56'h0, s_out.KEEP}, 64'h0);
    chk("rst_out_last", {63'h0, s_out.LAST}, 64'h0);
    chk("rst_dest", {56'h0, s_out.DEST}, 64'h0);
    chk("rst_src_mac", {16'h0, s_out.SRC_MAC}, 64'h0);
    chk("rst_in_ready", {63'h0, s_in.READY}, 64'h1);
    chk_counters("rst");
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Matched frame, one-cycle payload latency
    send(HdrMatch0, 8'hff, 1'b0);
    send(HdrMatch1, 8'hff, 1'b0);
    chk("hdr_no_output", {63'h0, s_out.VALID}, 64'h0);
    send(64'h0100000100030000, 8'hff, 1'b0);
    chk("lat_valid", {63'h0, s_out.VALID}, 64'h1);
    chk("lat_data", s_out.DATA, 64'h0100000100030000);
    send(64'h5073930200000000, 8'h0f, 1'b1);
    idle(3);
    chk("match_count", 64'(got_q.size()), 64'd2);
    chk_beat("match_b0", 0, 64'h0100000100030000, 8'hff, 1'b0, 8'h05, SrcMatch);
    chk_beat("match_b1", 1, 64'h5073930200000000, 8'h0f, 1'b1, 8'h05, SrcMatch);
    exp_ok = 1;
    chk_counters("match");
    got_q.delete();

    // Wrong destination: dropped, input never stalls
    stalls = 0;
    vc0 = valid_cycles;
    send(HdrWrong0, 8'hff, 1'b0);
    send(HdrMatch1, 8'hff, 1'b0);
    for (int i = 0; i < 3; i++) send(64'h3300000000000000 + 64'(i), 8'hff, i == 2);
    idle(3);
    chk("drop_stalls", 64'(stalls), 64'd0);
    chk("drop_valid_cycles", 64'(valid_cycles - vc0), 64'd0);
    chk("drop_count", 64'(got_q.size()), 64'd0);
    exp_drop = 1;
    chk_counters("drop");
    got_q.delete();

    // Broadcast destination
    send(HdrBcast0, 8'hff, 1'b0);
    send(HdrBcast1, 8'hff, 1'b0);
    send(64'h1111111111111111, 8'hff, 1'b0);
    send(64'h2222222222222222, 8'h3f, 1'b1);
    idle(3);
    chk("bcast_count", 64'(got_q.size()), 64'd2);
    chk_beat("bcast_b0", 0, 64'h1111111111111111, 8'hff, 1'b0, 8'h09, SrcBcast);
    chk_beat("bcast_b1", 1, 64'h2222222222222222, 8'h3f, 1'b1, 8'h09, SrcBcast);
    exp_ok = 2;
    chk_counters("bcast");
    got_q.delete();

    // Header-only runt, then a good frame back to back
    vc0 = valid_cycles;
    send(HdrMatch0, 8'hff, 1'b0);
    send(HdrMatch1, 8'hff, 1'b1);
    chk("runt_valid_cycles", 64'(valid_cycles - vc0), 64'd0);
    send(HdrMatch0, 8'hff, 1'b0);
    send(HdrMatch1, 8'hff, 1'b0);
    send(64'hdeadbeefcafef00d, 8'hff, 1'b1);
    idle(3);
    chk("runt_next_count", 64'(got_q.size()), 64'd1);
    chk_beat("runt_next_b0", 0, 64'hdeadbeefcafef00d, 8'hff, 1'b1, 8'h05, SrcMatch);
    exp_drop = 2;
    exp_ok = 3;
    chk_counters("runt");
    got_q.delete();

    // Downstream backpressure for 5 cycles mid-payload
    fork
      begin
        send(HdrMatch0, 8'hff, 1'b0);
        send(HdrMatch1, 8'hff, 1'b0);
        for (int i = 0; i < 6; i++) send(64'h0a00000000000000 + 64'(i), 8'hff, i == 5);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        s_out.READY = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_valid", {63'h0, s_out.VALID}, 64'h1);
          chk("bp_hold_data", s_out.DATA, 64'h0a00000000000001);
          chk("bp_in_ready", {63'h0, s_in.READY}, 64'h0);
        end
        @(posedge clk);
        #1;
        s_out.READY = 1'b1;
      end
    join
    idle(3);
    chk("bp_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk_beat("bp_beat", i, 64'h0a00000000000000 + 64'(i), 8'hff, i == 5, 8'h05, SrcMatch);
    exp_ok = 4;
    chk_counters("bp");
    got_q.delete();

    // Asynchronous reset while a payload beat is held in PASS
    send(HdrMatch0, 8'hff, 1'b0);
    send(HdrMatch1, 8'hff, 1'b0);
    send(64'h7777777777777777, 8'hff, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'h0, s_out.VALID}, 64'h0);
    chk("arst_dest", {56'h0, s_out.DEST}, 64'h0);
    chk("arst_in_ready", {63'h0, s_in.READY}, 64'h1);
    exp_ok = 0;
    exp_drop = 0;
    chk_counters("arst");
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send(HdrBcast0, 8'hff, 1'b0);
    send(HdrBcast1, 8'hff, 1'b0);
    send(64'h8888888888888888, 8'h01, 1'b1);
    idle(3);
    chk("arst_next_count", 64'(got_q.size()), 64'd1);
    chk_beat("arst_next_b0", 0, 64'h8888888888888888, 8'h01, 1'b1, 8'h09, SrcBcast);
    exp_ok = 1;
    chk_counters("arst_next");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
